// File: rtl/soc_bus_pkg.sv
// Shared DBus definitions: bus widths, responder FSM states and jitter LFSR constants.
// The LFSR items are only referenced when DBUS_RESP_JITTER_EN is defined.
package soc_bus_pkg;

  localparam int DBUS_ADDR_W = 32;
  localparam int DBUS_DATA_W = 32;
  localparam int DBUS_LANES  = DBUS_DATA_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dbus_state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] i_State);
    return {i_State[6:0], ^(i_State & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dbus_sram_array.sv
// Single-port word SRAM with per-lane write enables and a registered read port.
// Only the read register is reset; the storage array keeps its contents.
module dbus_sram_array
  import soc_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int DATA_WIDTH  = DBUS_DATA_W,
  parameter int LANES       = DATA_WIDTH / 8,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_En,
  input  logic                  i_Wr,
  input  logic [IDX_W-1:0]      i_Idx,
  input  logic [LANES-1:0]      i_ByteEn,
  input  logic [DATA_WIDTH-1:0] i_WrData,
  output logic [DATA_WIDTH-1:0] o_RdData
);

  logic [DATA_WIDTH-1:0] r_Mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] r_RdData;

  // Writes are blocked while reset is held so a pending store is never committed.
  always_ff @(posedge i_Clk) begin
    if (i_Rst_n && i_En && i_Wr) begin
      for (int b = 0; b < LANES; b++) begin
        if (i_ByteEn[b]) begin
          r_Mem[i_Idx][8*b +: 8] <= i_WrData[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_RdData <= '0;
    end else if (i_En && !i_Wr) begin
      r_RdData <= r_Mem[i_Idx];
    end
  end

  assign o_RdData = r_RdData;

endmodule

// File: rtl/dbus_sram_responder.sv
// DBus slave responder for a tightly-coupled word SRAM: address decode, grant and wait-state FSM.
// Optional build macro DBUS_RESP_JITTER_EN adds LFSR-driven random extra wait states.
module dbus_sram_responder
  import soc_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DBUS_ADDR_W,
  parameter int                    DATA_WIDTH  = DBUS_DATA_W,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic                    i_Req,
  input  logic [ADDR_WIDTH-1:0]   i_Addr,
  input  logic                    i_Wr,
  input  logic [DATA_WIDTH/8-1:0] i_ByteEn,
  input  logic [DATA_WIDTH-1:0]   i_WrData,
  output logic                    o_Gnt,
  output logic                    o_WaitReq,
  output logic [DATA_WIDTH-1:0]   o_RdData,
  output logic                    o_RdValid
);

  localparam int                    LANES     = DATA_WIDTH / 8;
  localparam int                    IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(4 * DEPTH_WORDS);

  dbus_state_e           r_State, w_StateNxt;
  logic [4:0]            r_Cnt, w_CntNxt;
  logic                  r_WaitReq, w_WaitReqNxt;
  logic                  r_RdValid;
  logic [IDX_W-1:0]      r_Idx;
  logic                  r_Wr;
  logic [LANES-1:0]      r_ByteEn;
  logic [DATA_WIDTH-1:0] r_WrData;

  logic [ADDR_WIDTH-1:0] w_Offset;
  logic                  w_Hit;
  logic                  w_Accept;
  logic [4:0]            w_N;
  logic                  w_MemEn;
  logic                  w_MemWr;
  logic [IDX_W-1:0]      w_MemIdx;
  logic [LANES-1:0]      w_MemBe;
  logic [DATA_WIDTH-1:0] w_MemWData;

  assign w_Offset = i_Addr - BASE_ADDR;
  assign w_Hit    = (i_Addr >= BASE_ADDR) && (w_Offset < WIN_BYTES);
  assign o_Gnt    = i_Req && w_Hit;
  assign w_Accept = o_Gnt && !r_WaitReq;

`ifdef DBUS_RESP_JITTER_EN
  logic [7:0] r_Lfsr;

  // Low LFSR bits stretch the wait count; the register steps once per accepted transfer.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Lfsr <= LFSR_SEED;
    end else if (w_Accept) begin
      r_Lfsr <= lfsr_next(r_Lfsr);
    end
  end

  assign w_N = 5'(WAIT_STATES) + {3'b000, r_Lfsr[1:0]};
`else
  assign w_N = 5'(WAIT_STATES);
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State   <= IDLE;
      r_Cnt     <= '0;
      r_WaitReq <= 1'b0;
      r_RdValid <= 1'b0;
    end else begin
      r_State   <= w_StateNxt;
      r_Cnt     <= w_CntNxt;
      r_WaitReq <= w_WaitReqNxt;
      r_RdValid <= w_MemEn && !w_MemWr;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Idx    <= '0;
      r_Wr     <= 1'b0;
      r_ByteEn <= '0;
      r_WrData <= '0;
    end else if (w_Accept) begin
      r_Idx    <= w_Offset[IDX_W+1:2];
      r_Wr     <= i_Wr;
      r_ByteEn <= i_ByteEn;
      r_WrData <= i_WrData;
    end
  end

  // Zero-wait transfers use the live bus; delayed ones replay the captured request on the last wait cycle.
  always_comb begin
    w_StateNxt   = r_State;
    w_CntNxt     = r_Cnt;
    w_WaitReqNxt = r_WaitReq;
    w_MemEn      = 1'b0;
    w_MemWr      = i_Wr;
    w_MemIdx     = w_Offset[IDX_W+1:2];
    w_MemBe      = i_ByteEn;
    w_MemWData   = i_WrData;
    case (r_State)
      IDLE: begin
        if (w_Accept) begin
          if (w_N == 5'd0) begin
            w_MemEn = 1'b1;
          end else begin
            w_StateNxt   = WAIT;
            w_CntNxt     = w_N;
            w_WaitReqNxt = 1'b1;
          end
        end
      end
      WAIT: begin
        w_MemWr    = r_Wr;
        w_MemIdx   = r_Idx;
        w_MemBe    = r_ByteEn;
        w_MemWData = r_WrData;
        if (r_Cnt == 5'd1) begin
          w_MemEn      = 1'b1;
          w_StateNxt   = IDLE;
          w_CntNxt     = 5'd0;
          w_WaitReqNxt = 1'b0;
        end else begin
          w_CntNxt = r_Cnt - 5'd1;
        end
      end
      default: begin
        w_StateNxt   = IDLE;
        w_CntNxt     = 5'd0;
        w_WaitReqNxt = 1'b0;
      end
    endcase
  end

  dbus_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_WIDTH  (DATA_WIDTH),
    .LANES       (LANES),
    .IDX_W       (IDX_W)
  ) u_array (
    .i_Clk    (i_Clk),
    .i_Rst_n  (i_Rst_n),
    .i_En     (w_MemEn),
    .i_Wr     (w_MemWr),
    .i_Idx    (w_MemIdx),
    .i_ByteEn (w_MemBe & {LANES{w_MemWr}}),
    .i_WrData (w_MemWData),
    .o_RdData (o_RdData)
  );

  assign o_WaitReq = r_WaitReq;
  assign o_RdValid = r_RdValid;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: a zero-wait instance and a three-wait instance share one bus driver.
// Honours DBUS_RESP_JITTER_EN by tracking the wait-count LFSR in the reference model.
module tb_dbus_sram_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  int          sel = 0;

  logic        req0, req1;
  logic        gnt0, gnt1, wait0, wait1, rdv0, rdv1;
  logic [31:0] rd0, rd1;
  logic        gnt, waitr, rdv;
  logic [31:0] rd;

  int nCmp = 0;
  int nFail = 0;

  // Reference model state: word contents with known-lane masks, last load result and per-instance LFSR.
  logic [31:0] memM [int];
  logic [3:0]  knM  [int];
  logic [31:0] lastRd [2];
  logic [3:0]  lastKn [2];
  logic [7:0]  lfsrM  [2];

  always #5 clk = ~clk;

  assign req0  = req && (sel == 0);
  assign req1  = req && (sel == 1);
  assign gnt   = (sel == 0) ? gnt0  : gnt1;
  assign waitr = (sel == 0) ? wait0 : wait1;
  assign rdv   = (sel == 0) ? rdv0  : rdv1;
  assign rd    = (sel == 0) ? rd0   : rd1;

  dbus_sram_responder #(.WAIT_STATES(0)) u_dut0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req0), .i_Addr(addr), .i_Wr(wr),
    .i_ByteEn(be), .i_WrData(wdata), .o_Gnt(gnt0), .o_WaitReq(wait0),
    .o_RdData(rd0), .o_RdValid(rdv0)
  );

  dbus_sram_responder #(.WAIT_STATES(3)) u_dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req1), .i_Addr(addr), .i_Wr(wr),
    .i_ByteEn(be), .i_WrData(wdata), .o_Gnt(gnt1), .o_WaitReq(wait1),
    .o_RdData(rd1), .o_RdValid(rdv1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit isHit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic int key(input int s, input logic [31:0] a);
    return s * DEPTH + int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] laneMask(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  task automatic modelReset();
    lfsrM[0] = 8'hA5;
    lfsrM[1] = 8'hA5;
    lastRd[0] = '0;
    lastRd[1] = '0;
    lastKn[0] = 4'hF;
    lastKn[1] = 4'hF;
  endtask

  // Wait count of the next accepted transfer on instance s.
  task automatic nextN(input int s, output int n);
    n = (s == 0) ? 0 : 3;
`ifdef DBUS_RESP_JITTER_EN
    n += int'(lfsrM[s][1:0]);
    lfsrM[s] = {lfsrM[s][6:0], lfsrM[s][7] ^ lfsrM[s][5] ^ lfsrM[s][4] ^ lfsrM[s][3]};
`endif
  endtask

  task automatic modelStore(input int s, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    int k;
    logic [31:0] w;
    logic [3:0]  kn;
    k  = key(s, a);
    w  = memM.exists(k) ? memM[k] : 32'h0;
    kn = knM.exists(k)  ? knM[k]  : 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        w[8*i +: 8] = d[8*i +: 8];
        kn[i] = 1'b1;
      end
    end
    memM[k] = w;
    knM[k]  = kn;
  endtask

  // One complete CPU transfer: request held while stalled, then dropped once WaitReq is low.
  task automatic applyStimulus(input int s, input logic [31:0] a, input logic w,
                               input logic [3:0] b, input logic [31:0] d);
    bit          h;
    int          n, waitCnt, rdvCnt, rdvAt, k;
    logic [31:0] rdAt, expD, m;
    logic [3:0]  expK;
    h = isHit(a);
    sel = s; addr = a; wr = w; be = b; wdata = d; req = 1'b1;
    #1;
    checkOutput("gnt", 32'(gnt), 32'(h));
    n = 0;
    if (h) nextN(s, n);
    @(posedge clk); #1;
    waitCnt = 0; rdvCnt = 0; rdvAt = 0; rdAt = '0;
    for (int c = 1; c <= n + 3; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (!waitr) req = 1'b0;
      if (waitr) waitCnt++;
      if (rdv) begin rdvCnt++; rdvAt = c; rdAt = rd; end
    end
    req = 1'b0;
    checkOutput("waitCycles", 32'(waitCnt), 32'(n));
    if (h && w) modelStore(s, a, b, d);
    if (h && !w) begin
      k    = key(s, a);
      expD = memM.exists(k) ? memM[k] : 32'h0;
      expK = knM.exists(k)  ? knM[k]  : 4'h0;
      checkOutput("rdValidCount", 32'(rdvCnt), 32'd1);
      checkOutput("rdLatency", 32'(rdvAt), 32'(n + 1));
      m = laneMask(expK);
      if (expK != 4'h0) checkOutput("rdData", rdAt & m, expD & m);
      lastRd[s] = expD;
      lastKn[s] = expK;
    end else begin
      checkOutput("rdValidCount", 32'(rdvCnt), 32'd0);
      m = laneMask(lastKn[s]);
      if (lastKn[s] != 4'h0) checkOutput("rdHold", rd & m, lastRd[s] & m);
    end
  endtask

  // Store followed by a load to the same word presented in the store's completion cycle.
  task automatic backToBack(input int s, input logic [31:0] a, input logic [31:0] d);
    int n1, n2, waitCnt, rdvAt, c;
    logic [31:0] rdAt;
    sel = s; addr = a; wr = 1'b1; be = 4'hF; wdata = d; req = 1'b1;
    nextN(s, n1);
    @(posedge clk); #1;
    c = 0;
    while (waitr && c < 25) begin
      c++;
      @(posedge clk); #1;
    end
    checkOutput("b2bStoreWaits", 32'(c), 32'(n1));
    checkOutput("b2bStoreDone", 32'(waitr), 32'd0);
    modelStore(s, a, 4'hF, d);
    wr = 1'b0;
    #1;
    checkOutput("b2bGnt", 32'(gnt), 32'd1);
    nextN(s, n2);
    @(posedge clk); #1;
    waitCnt = 0; rdvAt = 0; rdAt = '0;
    for (int k = 1; k <= n2 + 2; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (!waitr) req = 1'b0;
      if (waitr) waitCnt++;
      if (rdv && rdvAt == 0) begin rdvAt = k; rdAt = rd; end
    end
    req = 1'b0;
    checkOutput("b2bLoadWaits", 32'(waitCnt), 32'(n2));
    checkOutput("b2bLatency", 32'(rdvAt), 32'(n2 + 1));
    checkOutput("b2bData", rdAt, d);
    lastRd[s] = d;
    lastKn[s] = 4'hF;
  endtask

  typedef struct {
    int          s;
    logic        w;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    bit          chk;
    logic [31:0] expRd;
  } vec_t;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[$];
    vecs.push_back('{0, 1'b1, 32'h1000_0010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h1000_0010, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b0, 32'h1000_0013, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF});
    vecs.push_back('{1, 1'b1, 32'h1000_0000, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h1000_0000, 4'h0, 32'h0,        1'b1, 32'hCAFEF00D});
    vecs.push_back('{1, 1'b1, 32'h1000_0020, 4'hF, 32'h11223344, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b1, 32'h1000_0020, 4'h5, 32'hAABBCCDD, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h1000_0020, 4'h0, 32'h0,        1'b1, 32'h11BB33DD});
    vecs.push_back('{1, 1'b1, 32'h1000_0020, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h1000_0020, 4'h0, 32'h0,        1'b1, 32'h11BB33DD});
    vecs.push_back('{1, 1'b0, 32'h2000_0000, 4'h0, 32'h0,        1'b1, 32'h11BB33DD});
    vecs.push_back('{1, 1'b1, 32'h2000_0020, 4'hF, 32'h0000AAAA, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h1000_0020, 4'h0, 32'h0,        1'b1, 32'h11BB33DD});
    vecs.push_back('{0, 1'b1, 32'h1000_0000, 4'hF, 32'h55AA55AA, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 32'h1000_0FFC, 4'hF, 32'h0BADF00D, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h1000_0FFC, 4'h0, 32'h0,        1'b1, 32'h0BADF00D});
    vecs.push_back('{0, 1'b1, 32'h1000_1000, 4'hF, 32'h12345678, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 32'h0FFF_FFFC, 4'hF, 32'h87654321, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h1000_0000, 4'h0, 32'h0,        1'b1, 32'h55AA55AA});
    vecs.push_back('{0, 1'b0, 32'h1000_0FFC, 4'h0, 32'h0,        1'b1, 32'h0BADF00D});

    modelReset();
    #12;
    checkOutput("rstWait0", 32'(wait0), 32'd0);
    checkOutput("rstWait1", 32'(wait1), 32'd0);
    checkOutput("rstRdValid", 32'({rdv0, rdv1}), 32'd0);
    checkOutput("rstRdData0", rd0, 32'h0);
    checkOutput("rstRdData1", rd1, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, vecs[i].a, vecs[i].w, vecs[i].be, vecs[i].d);
      if (vecs[i].chk) checkOutput($sformatf("tableRd[%0d]", i), rd, vecs[i].expRd);
    end

    $display("[TB] back-to-back store/load");
    backToBack(0, 32'h1000_0100, 32'hA5A5_0001);
    backToBack(1, 32'h1000_0104, 32'h5A5A_0002);

    $display("[TB] reset during wait states");
    applyStimulus(1, 32'h1000_0040, 1'b1, 4'hF, 32'h0102_0304);
    sel = 1; addr = 32'h1000_0040; wr = 1'b1; be = 4'hF; wdata = 32'hFFFF_FFFF; req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("preRstWait", 32'(wait1), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstWait", 32'(wait1), 32'd0);
    checkOutput("midRstRdValid", 32'({rdv0, rdv1}), 32'd0);
    checkOutput("midRstRdData", rd1 | rd0, 32'h0);
    req = 1'b0;
    modelReset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1, 32'h1000_0040, 1'b0, 4'h0, 32'h0);
    checkOutput("postRstWord", rd1, 32'h0102_0304);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 150; i++) begin
      int          s;
      logic [31:0] a;
      s = int'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       a = BASE - 32'($urandom_range(1, 64));
        1:       a = BASE + 32'h1000 + 32'($urandom_range(0, 64));
        2:       a = $urandom;
        3:       a = BASE + ($urandom & 32'h0000_0FFF);
        default: a = BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      endcase
      applyStimulus(s, a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
